// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, fetches from a combinational imem into a 2-entry prefetch queue.
// Latency: word fetched at edge N is presented to decode in cycle N+1; redirects cost a 2-cycle bubble.
// Backpressure: if_ready low lets the queue fill to 2 and then freezes the PC. Optional FETCH_STATS_EN adds a delivered-instruction counter.
module fetch_sequencer #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter logic [3:0] HALT_OPCODE = 4'h4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [7:0]  imem_addr,
    input  logic [15:0] imem_data,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [7:0]  if_pc,
    input  logic        if_ready,
    input  logic        redirect_valid,
    input  logic [7:0]  redirect_pc,
    output logic        halted,
    output logic [15:0] fetch_count
);

    // Fetch FSM encoding; HALTED only stops new fetches, the queue keeps draining.
    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    // One prefetch-queue slot: the word and the address it came from.
    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] instr;
    } entry_t;

    logic [7:0]  pc_q, pc_d;
    logic [0:0]  state_q, state_d;
    logic        head_q, head_d;
    logic        tail_q, tail_d;
    logic [1:0]  count_q, count_d;
    entry_t      slot_q [2];
    entry_t      head_entry;

    logic        pop;
    logic        fetch_en;
    logic        push;
    logic        halt_hit;

    // Memory address is the PC itself; no extra pipeline stage on the fetch path.
    assign imem_addr  = pc_q;

    // Decode-side view of the queue head.
    assign head_entry = slot_q[head_q];
    assign if_valid   = (count_q != 2'd0);
    assign if_instr   = head_entry.instr;
    assign if_pc      = head_entry.pc;
    assign halted     = (state_q == ST_HALTED);

    // A pop is a completed handshake; it counts as delivered even if a redirect flushes the queue.
    assign pop      = if_valid && if_ready;
    // Redirect suppresses fetch in its own cycle so the flushed queue never sees a stale word.
    assign fetch_en = (state_q == ST_RUN) && !redirect_valid;
    // Full queue can still accept a word when the head leaves in the same cycle.
    assign push     = fetch_en && ((count_q != 2'd2) || pop);
    assign halt_hit = push && (imem_data[15:12] == HALT_OPCODE);

    // Next-state logic for PC, pointers, occupancy and FSM; redirect overrides everything else.
    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            state_d = ST_RUN;
            head_d  = 1'b0;
            tail_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if (push) begin
                tail_d = ~tail_q;
                if (halt_hit) begin
                    // Halt word is still delivered; PC parks on it so imem_addr shows where we stopped.
                    state_d = ST_HALTED;
                end else begin
                    pc_d = pc_q + 8'd1;
                end
            end
            if (pop) begin
                head_d = ~head_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers; reset wins over any pending push, pop or redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            state_q <= ST_RUN;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Queue storage; cleared on reset so an empty head reads as zero after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                slot_q[i] <= '0;
            end
        end else if (push) begin
            slot_q[tail_q] <= '{pc: pc_q, instr: imem_data};
        end
    end

`ifdef FETCH_STATS_EN
    logic [15:0] fetch_count_q;

    // Delivered-instruction counter: every completed handshake, wrapping naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q <= 16'h0000;
        end else if (pop) begin
            fetch_count_q <= fetch_count_q + 16'd1;
        end
    end

    assign fetch_count = fetch_count_q;
`else
    assign fetch_count = 16'h0000;
`endif

endmodule
